// File: rtl/interrupt_service_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_service_controller
// Description : Requester-side companion of a round-robin arbiter. Captures
//               rising edges on irq_in into a pending vector, steps the
//               arbiter with a one-cycle ack, then offers the granted index
//               to a service engine over valid/ready and clears the pending
//               bit on svc_done.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_service_controller #(
  parameter  int BUS_WIDTH = 32,
  localparam int ID_W      = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] irq_in,
  output logic [BUS_WIDTH-1:0] interrupt_bus,
  input  logic [ID_W-1:0]      bus_priority,
  output logic                 arbitration_ack,
  output logic                 svc_valid,
  output logic [ID_W-1:0]      svc_id,
  input  logic                 svc_ready,
  input  logic                 svc_done,
  output logic                 busy,
  output logic                 irq_lost
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_arb     = 3'd1;
  localparam logic [2:0] c_st_settle  = 3'd2;
  localparam logic [2:0] c_st_offer   = 3'd3;
  localparam logic [2:0] c_st_service = 3'd4;

  logic [2:0]           r_state;
  logic [BUS_WIDTH-1:0] r_irq_q;
  logic [BUS_WIDTH-1:0] r_pending;
  logic [ID_W-1:0]      r_svc_id;
  logic                 r_irq_lost;
  logic [BUS_WIDTH-1:0] w_edge;
  logic [BUS_WIDTH-1:0] w_clear;

  assign w_edge = irq_in & ~r_irq_q;

  // One-hot clear mask: only the serviced line, only when completion is seen
  always_comb begin
    w_clear = '0;
    if ((r_state == c_st_service) && svc_done) begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        if (ID_W'(i) == r_svc_id) begin
          w_clear[i] = 1'b1;
        end
      end
    end
  end

  // Edge history, pending vector (set beats clear) and coalesced loss flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_q    <= '0;
      r_pending  <= '0;
      r_irq_lost <= 1'b0;
    end else begin
      r_irq_q    <= irq_in;
      r_pending  <= (r_pending & ~w_clear) | w_edge;
      r_irq_lost <= |(w_edge & r_pending & ~w_clear);
    end
  end

  // Service sequencer; svc_id is captured one cycle after the ack so the
  // arbiter has had its update edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_st_idle;
      r_svc_id <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (|r_pending) begin
            r_state <= c_st_arb;
          end
        end
        c_st_arb: begin
          r_state <= c_st_settle;
        end
        c_st_settle: begin
          r_svc_id <= bus_priority;
          r_state  <= c_st_offer;
        end
        c_st_offer: begin
          if (svc_ready) begin
            r_state <= c_st_service;
          end
        end
        c_st_service: begin
          if (svc_done) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign interrupt_bus   = r_pending;
  assign arbitration_ack = (r_state == c_st_arb);
  assign svc_valid       = (r_state == c_st_offer);
  assign svc_id          = r_svc_id;
  assign busy            = (r_state != c_st_idle);
  assign irq_lost        = r_irq_lost;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_service_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_service_controller
// Description : Directed bench for interrupt_service_controller with a small
//               behavioural round-robin arbiter driving bus_priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_service_controller;

  localparam int BW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] irq_in;
  logic [BW-1:0] interrupt_bus;
  logic [IW-1:0] bus_priority;
  logic          arbitration_ack;
  logic          svc_valid;
  logic [IW-1:0] svc_id;
  logic          svc_ready;
  logic          svc_done;
  logic          busy;
  logic          irq_lost;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int ack_base = 0;

  interrupt_service_controller #(.BUS_WIDTH(BW)) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_in          (irq_in),
    .interrupt_bus   (interrupt_bus),
    .bus_priority    (bus_priority),
    .arbitration_ack (arbitration_ack),
    .svc_valid       (svc_valid),
    .svc_id          (svc_id),
    .svc_ready       (svc_ready),
    .svc_done        (svc_done),
    .busy            (busy),
    .irq_lost        (irq_lost)
  );

  always #5 clk = ~clk;

  // Next pending index strictly after the current grant, wrapping
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] p, input logic [BW-1:0] req);
    logic [IW-1:0] idx;
    for (int k = 1; k <= BW; k++) begin
      idx = IW'((int'(p) + k) % BW);
      if (req[idx]) return idx;
    end
    return p;
  endfunction

  // Round-robin arbiter model: advances on each ack
  always @(posedge clk or negedge rst) begin
    if (!rst) bus_priority <= '0;
    else if (arbitration_ack) bus_priority <= rr_next(bus_priority, interrupt_bus);
  end

  // Ack pulse counter
  always @(posedge clk) begin
    if (arbitration_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; svc_ready = 1'b0; svc_done = 1'b0;
    tick(); tick();
    check("rst_bus", interrupt_bus, 0);
    check("rst_ack", arbitration_ack, 0);
    check("rst_valid", svc_valid, 0);
    check("rst_id", svc_id, 0);
    check("rst_busy", busy, 0);
    check("rst_lost", irq_lost, 0);
    rst = 1'b1; svc_ready = 1'b1; svc_done = 1'b1;
    tick();

    // Round-robin order: lines 0 and 3 together, grant starts at 0
    irq_in = 8'h09; tick(); irq_in = '0;
    check("rr_bus0", interrupt_bus, 8'h09);
    check("rr_idle", busy, 0);
    tick(); check("rr_ack1", arbitration_ack, 1); check("rr_busy", busy, 1);
    tick(); check("rr_ack1_end", arbitration_ack, 0); check("rr_settle_valid", svc_valid, 0);
    tick(); check("rr_valid1", svc_valid, 1); check("rr_id1", svc_id, 3);
    tick(); check("rr_svc_valid", svc_valid, 0);
    tick(); check("rr_bus1", interrupt_bus, 8'h01); check("rr_idle1", busy, 0);
    tick(); check("rr_ack2", arbitration_ack, 1);
    tick();
    tick(); check("rr_id2", svc_id, 0); check("rr_valid2", svc_valid, 1);
    tick();
    tick(); check("rr_bus2", interrupt_bus, 8'h00); check("rr_idle2", busy, 0);
    check("rr_ack_count", ack_cnt, 2);

    // Single line 5
    ack_base = ack_cnt;
    irq_in = 8'h20; tick(); irq_in = '0;
    check("single_bus", interrupt_bus, 8'h20);
    tick(); check("single_ack", arbitration_ack, 1);
    tick();
    tick(); check("single_valid", svc_valid, 1); check("single_id", svc_id, 5);
    tick();
    tick(); check("single_bus_clr", interrupt_bus, 0); check("single_idle", busy, 0);
    check("single_ack_count", ack_cnt - ack_base, 1);

    // Backpressure on line 2 with line 6 arriving meanwhile
    svc_ready = 1'b0;
    irq_in = 8'h04; tick(); irq_in = '0;
    tick(); tick();
    tick(); check("bp_id", svc_id, 2); check("bp_valid", svc_valid, 1);
    ack_base = ack_cnt;
    for (int i = 0; i < 10; i++) begin
      irq_in = (i == 3) ? 8'h40 : 8'h00;
      tick();
      check("bp_hold_valid", svc_valid, 1);
      check("bp_hold_id", svc_id, 2);
    end
    irq_in = '0;
    check("bp_bus", interrupt_bus, 8'h44);
    check("bp_no_ack", ack_cnt - ack_base, 0);
    svc_ready = 1'b1;
    tick(); check("bp_accept", svc_valid, 0);
    tick(); check("bp_bus_after", interrupt_bus, 8'h40);
    tick(); tick();
    tick(); check("bp_id6", svc_id, 6);
    tick();
    tick(); check("bp_bus_done", interrupt_bus, 0); check("bp_idle", busy, 0);

    // Set/clear collision on line 2
    svc_done = 1'b0;
    irq_in = 8'h04; tick(); irq_in = '0;
    tick(); tick();
    tick(); check("col_id", svc_id, 2);
    tick(); check("col_service", busy, 1);
    tick(); check("col_wait", interrupt_bus, 8'h04); check("col_wait_busy", busy, 1);
    svc_done = 1'b1; irq_in = 8'h04;
    tick(); irq_in = '0;
    check("col_bus", interrupt_bus, 8'h04);
    check("col_idle", busy, 0);
    check("col_nolost", irq_lost, 0);
    tick(); check("col_ack", arbitration_ack, 1);
    tick();
    tick(); check("col_id2", svc_id, 2); check("col_valid2", svc_valid, 1);
    tick();
    tick(); check("col_bus_clr", interrupt_bus, 0);

    // Lost edge on pending line 4
    svc_done = 1'b0; svc_ready = 1'b0;
    irq_in = 8'h10; tick();
    irq_in = 8'h00; tick(); check("lost_pre", irq_lost, 0);
    irq_in = 8'h10; tick(); check("lost_pulse", irq_lost, 1);
    irq_in = 8'h00; tick(); check("lost_end", irq_lost, 0);
    check("lost_id", svc_id, 4); check("lost_bus", interrupt_bus, 8'h10);
    svc_ready = 1'b1; svc_done = 1'b1;
    tick();
    tick(); check("lost_bus_clr", interrupt_bus, 0);

    // Reset mid-service with 0x81 pending
    svc_done = 1'b0;
    irq_in = 8'h81; tick();
    tick(); tick();
    tick(); check("mr_id", svc_id, 7);
    tick(); check("mr_busy", busy, 1); check("mr_bus", interrupt_bus, 8'h81);
    irq_in = 8'h80;
    #2 rst = 1'b0;
    #1;
    check("mr_bus0", interrupt_bus, 0);
    check("mr_busy0", busy, 0);
    check("mr_id0", svc_id, 0);
    check("mr_valid0", svc_valid, 0);
    check("mr_ack0", arbitration_ack, 0);
    @(negedge clk);
    rst = 1'b1; svc_done = 1'b1;
    ack_base = ack_cnt;
    tick(); check("mr_bus7", interrupt_bus, 8'h80);
    tick(); tick();
    tick(); check("mr_id7", svc_id, 7);
    tick();
    tick(); check("mr_bus_clr", interrupt_bus, 0);
    repeat (4) tick();
    check("mr_one_ack", ack_cnt - ack_base, 1);
    check("mr_quiet", busy, 0);
    irq_in = '0;

    // Wrap-around: grant sits at 7, line 1 pends
    tick();
    irq_in = 8'h02; tick(); irq_in = '0;
    tick(); tick();
    tick(); check("wrap_id", svc_id, 1); check("wrap_valid", svc_valid, 1);
    tick();
    tick(); check("wrap_bus", interrupt_bus, 0); check("wrap_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
